// File: rtl/slowdoor_fabric_pkg.sv
// SlowDoor fabric shared definitions: config word field offsets and width.
// Field order, LSB first: lut, sel[0..K-1], out_sel, reg_mode, enable.
package slowdoor_fabric_pkg;

   function automatic int unsigned lut_lsb();
      return 0;
   endfunction

   function automatic int unsigned sel_lsb(int unsigned k, int unsigned sw, int unsigned j);
      return (2 ** k) + j * sw;
   endfunction

   function automatic int unsigned out_sel_lsb(int unsigned k, int unsigned sw);
      return (2 ** k) + k * sw;
   endfunction

   function automatic int unsigned reg_mode_bit(int unsigned k, int unsigned sw);
      return out_sel_lsb(k, sw) + sw;
   endfunction

   function automatic int unsigned enable_bit(int unsigned k, int unsigned sw);
      return reg_mode_bit(k, sw) + 1;
   endfunction

   function automatic int unsigned cfg_w(int unsigned k, int unsigned num_sides);
      return (2 ** k) + (k + 1) * $clog2(num_sides) + 2;
   endfunction

endpackage

// File: rtl/slowdoor_cfg_chain.sv
// Serial scan register with a shadow active copy. Shifting never touches the
// live configuration; only cfg_load transfers scan into active.
module slowdoor_cfg_chain #(
   parameter int unsigned W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_shift,
   input  logic         cfg_si,
   input  logic         cfg_load,
   output logic         cfg_so,
   output logic [W-1:0] active
);

   logic [W-1:0] scan_q;
   logic [W-1:0] active_q;

   // Scan shift and shadow load; load samples the pre-shift scan contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_q   <= '0;
         active_q <= '0;
      end else begin
         if (cfg_shift) scan_q <= {scan_q[W-2:0], cfg_si};
         if (cfg_load)  active_q <= scan_q;
      end
   end

   assign cfg_so = scan_q[W-1];
   assign active = active_q;

endmodule

// File: rtl/slowdoor_logic_cell.sv
// SlowDoor K-input LUT logic cell with side routing, optional output register
// and a daisy-chained configuration scan path.
module slowdoor_logic_cell
   import slowdoor_fabric_pkg::*;
#(
   parameter int unsigned LUT_K     = 2,
   parameter int unsigned NUM_SIDES = 4,
   parameter int unsigned SEL_W     = $clog2(NUM_SIDES),
   parameter int unsigned CFG_W     = cfg_w(LUT_K, NUM_SIDES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_shift,
   input  logic                 cfg_si,
   output logic                 cfg_so,
   input  logic                 cfg_load,
   input  logic [NUM_SIDES-1:0] side_valid_i,
   input  logic [NUM_SIDES-1:0] side_data_i,
   output logic [NUM_SIDES-1:0] side_valid_o,
   output logic [NUM_SIDES-1:0] side_data_o
);

   localparam int unsigned LutN      = 2 ** LUT_K;
   localparam int unsigned LutLsb    = lut_lsb();
   localparam int unsigned OutSelLsb = out_sel_lsb(LUT_K, SEL_W);
   localparam int unsigned RegBit    = reg_mode_bit(LUT_K, SEL_W);
   localparam int unsigned EnBit     = enable_bit(LUT_K, SEL_W);
   localparam logic [SEL_W:0] NumSidesW = (SEL_W + 1)'(NUM_SIDES);

   logic [CFG_W-1:0] active;
   logic [LutN-1:0]  lut;
   logic [SEL_W-1:0] sel [LUT_K];
   logic [SEL_W-1:0] out_sel;
   logic             reg_mode;
   logic             enable;
   logic             out_ok;
   logic [LUT_K-1:0] addr;
   logic             res_valid;
   logic             res;
   logic             out_valid_q;
   logic             out_data_q;

   slowdoor_cfg_chain #(
      .W (CFG_W)
   ) u_cfg_chain (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_shift (cfg_shift),
      .cfg_si    (cfg_si),
      .cfg_load  (cfg_load),
      .cfg_so    (cfg_so),
      .active    (active)
   );

   // Field decode, LUT input routing and loop/range qualification of res_valid.
   always_comb begin
      lut       = active[LutLsb +: LutN];
      out_sel   = active[OutSelLsb +: SEL_W];
      reg_mode  = active[RegBit];
      enable    = active[EnBit];
      out_ok    = ({1'b0, out_sel} < NumSidesW);
      res_valid = out_ok;
      addr      = '0;
      for (int j = 0; j < LUT_K; j++) begin
         sel[j] = active[sel_lsb(LUT_K, SEL_W, j) +: SEL_W];
         if (({1'b0, sel[j]} >= NumSidesW) || (sel[j] == out_sel)) begin
            res_valid = 1'b0;
         end else begin
            addr[j]   = side_data_i[sel[j]];
            res_valid = res_valid & side_valid_i[sel[j]];
         end
      end
      res = lut[addr];
   end

   // Output register; cleared on load so a new out_sel never shows stale data.
   always_ff @(posedge clk) begin
      if (!rst_n || cfg_load) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
      end else begin
         out_valid_q <= res_valid;
         out_data_q  <= res & res_valid;
      end
   end

   // Drive only the selected side; everything else (and a disabled cell) reads 0.
   always_comb begin
      side_valid_o = '0;
      side_data_o  = '0;
      if (enable && out_ok) begin
         side_valid_o[out_sel] = reg_mode ? out_valid_q : res_valid;
         side_data_o[out_sel]  = reg_mode ? out_data_q  : (res & res_valid);
      end
   end

endmodule
